// File: rtl/pipe_stage_buffer_if.sv
// Handshake and payload bundle between two pipeline stages.
// master: upstream producer / downstream consumer side (the environment).
// slave:  the stage buffer itself.
interface pipe_stage_buffer_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CTRL_W   = 32,
    parameter int unsigned NUM_DATA = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_pc;
    logic [DATA_W-1:0]            in_inst;
    logic [CTRL_W-1:0]            in_ctrl;
    logic [NUM_DATA*DATA_W-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_pc;
    logic [DATA_W-1:0]            out_inst;
    logic [CTRL_W-1:0]            out_ctrl;
    logic [NUM_DATA*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_pc, in_inst, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register for the LC-3b pipelined datapath.
// Holds PC, instruction, control word and NUM_DATA data words with valid/ready
// on both sides, a flush for branch squash and a saturating stall counter.
// Build option: define PIPE_SKID_EN for a 2-entry skid buffer (registered
// in_ready); otherwise a single entry with combinational in_ready.
module pipe_stage_buffer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CTRL_W   = 32,
    parameter int unsigned NUM_DATA = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    pipe_stage_buffer_if.slave    bus,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]          pc;
        logic [DATA_W-1:0]          inst;
        logic [CTRL_W-1:0]          ctrl;
        logic [NUM_DATA*DATA_W-1:0] data;
    } payload_t;

    payload_t         in_pay;
    payload_t         m_q;
    logic             m_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] stall_cnt_q;

    // Gather the upstream fields into one payload word.
    always_comb begin
        in_pay.pc   = bus.in_pc;
        in_pay.inst = bus.in_inst;
        in_pay.ctrl = bus.in_ctrl;
        in_pay.data = bus.in_data;
    end

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = m_valid_q & bus.out_ready;

`ifdef PIPE_SKID_EN
    payload_t s_q;
    logic     s_valid_q;

    // Registered ready: no combinational path from out_ready.
    assign bus.in_ready = ~s_valid_q;

    // Main/skid entries; S only fills while M is stalled, and refills M first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
        end else if (flush) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else if (!m_valid_q) begin
            if (in_fire) begin
                m_q       <= in_pay;
                m_valid_q <= 1'b1;
            end
        end else if (out_fire) begin
            if (s_valid_q) begin
                m_q       <= s_q;
                s_valid_q <= 1'b0;
            end else if (in_fire) begin
                m_q <= in_pay;
            end else begin
                m_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            s_q       <= in_pay;
            s_valid_q <= 1'b1;
        end
    end
`else
    // Single entry: accept when empty or when draining this cycle.
    assign bus.in_ready = ~m_valid_q | bus.out_ready;

    // Main entry load/drain; a simultaneous in/out transfer replaces M.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_q       <= '0;
        end else if (flush) begin
            m_valid_q <= 1'b0;
        end else if (in_fire) begin
            m_q       <= in_pay;
            m_valid_q <= 1'b1;
        end else if (out_fire) begin
            m_valid_q <= 1'b0;
        end
    end
`endif

    // Saturating count of downstream back-pressure cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (m_valid_q && !bus.out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign bus.out_valid = m_valid_q;
    assign bus.out_pc    = m_q.pc;
    assign bus.out_inst  = m_q.inst;
    assign bus.out_data  = m_q.data;
    // Stale payload stays in M after flush; masking ctrl makes it a NOP.
    assign bus.out_ctrl  = m_valid_q ? m_q.ctrl : '0;

endmodule
